// File: rtl/wordle_guess_scorer_if.sv
// Guess/score handshake between the game sequencer and the scorer.
// The sequencer drives Start/guess/target; the scorer returns busy/done/colors/win.
interface wordle_guess_scorer_if;
  logic        Start;
  logic [39:0] guess;
  logic [39:0] target;
  logic        busy;
  logic        done;
  logic [9:0]  colors;
  logic        win;

  modport master (output Start, guess, target, input busy, done, colors, win);
  modport slave  (input Start, guess, target, output busy, done, colors, win);
endinterface

// File: rtl/wordle_guess_scorer.sv
// Scores one 5-letter guess against the hidden word: a green pass, then a 5x5 yellow scan
// that consumes target letters so repeated letters are counted only as often as they occur.
module wordle_guess_scorer #(
  parameter int N_LET = 5,
  parameter int W_CH  = 8
) (
  input  logic                 Clk,
  input  logic                 reset,
  wordle_guess_scorer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, GREEN, YELLOW, DONE} state_t;

  localparam logic [1:0] C_GREY   = 2'b01;
  localparam logic [1:0] C_YELLOW = 2'b10;
  localparam logic [1:0] C_GREEN  = 2'b11;
  localparam logic [2:0] LAST     = 3'(N_LET - 1);

  state_t r_state, w_state_nxt;

  // Ascending packed ranges keep letter0 at the MSB end, matching the bus byte order.
  logic [0:N_LET-1][W_CH-1:0] r_g, r_t, w_g_nxt, w_t_nxt;
  logic [0:N_LET-1][1:0]      r_col, w_col_nxt;
  logic [0:N_LET-1]           r_used, w_used_nxt;
  logic [2:0]                 r_i, r_j, w_i_nxt, w_j_nxt;
  logic [0:N_LET-1][1:0]      r_colors;
  logic                       r_win;
  logic                       w_load_out;

  always_ff @(posedge Clk) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_g_nxt     = r_g;
    w_t_nxt     = r_t;
    w_col_nxt   = r_col;
    w_used_nxt  = r_used;
    w_i_nxt     = r_i;
    w_j_nxt     = r_j;
    w_load_out  = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.Start) begin
          w_g_nxt     = bus.guess;
          w_t_nxt     = bus.target;
          w_used_nxt  = '0;
          w_col_nxt   = {N_LET{C_GREY}};
          w_i_nxt     = '0;
          w_j_nxt     = '0;
          w_state_nxt = GREEN;
        end
      end
      GREEN: begin
        if (r_g[r_i] == r_t[r_i]) begin
          w_col_nxt[r_i]  = C_GREEN;
          w_used_nxt[r_i] = 1'b1;
        end
        if (r_i == LAST) begin
          w_i_nxt     = '0;
          w_j_nxt     = '0;
          w_state_nxt = YELLOW;
        end else begin
          w_i_nxt = r_i + 3'd1;
        end
      end
      YELLOW: begin
        // Once a letter turns yellow its colour is no longer grey, so later j steps are no-ops.
        if (r_col[r_i] == C_GREY && !r_used[r_j] && r_g[r_i] == r_t[r_j]) begin
          w_col_nxt[r_i]  = C_YELLOW;
          w_used_nxt[r_j] = 1'b1;
        end
        if (r_j == LAST) begin
          w_j_nxt = '0;
          if (r_i == LAST) begin
            w_i_nxt     = '0;
            w_load_out  = 1'b1;
            w_state_nxt = DONE;
          end else begin
            w_i_nxt = r_i + 3'd1;
          end
        end else begin
          w_j_nxt = r_j + 3'd1;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!reset) begin
      r_g      <= '0;
      r_t      <= '0;
      r_col    <= '0;
      r_used   <= '0;
      r_i      <= '0;
      r_j      <= '0;
      r_colors <= '0;
      r_win    <= 1'b0;
    end else begin
      r_g    <= w_g_nxt;
      r_t    <= w_t_nxt;
      r_col  <= w_col_nxt;
      r_used <= w_used_nxt;
      r_i    <= w_i_nxt;
      r_j    <= w_j_nxt;
      // Published on entry to DONE so colors/win are already valid in the done cycle.
      if (w_load_out) begin
        r_colors <= w_col_nxt;
        r_win    <= (w_col_nxt == {N_LET{C_GREEN}});
      end
    end
  end

  assign bus.busy   = (r_state != IDLE);
  assign bus.done   = (r_state == DONE);
  assign bus.colors = r_colors;
  assign bus.win    = r_win;

endmodule

// File: tb/tb_wordle_guess_scorer.sv
// Directed bench for wordle_guess_scorer: latency, duplicate-letter scoring, ignored Start, mid-scan reset.
module tb_wordle_guess_scorer;

  logic Clk;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  wordle_guess_scorer_if bus();

  wordle_guess_scorer dut (.Clk(Clk), .reset(reset), .bus(bus));

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge. Returns negedges until done (-1 if none within 40) and busy cycles seen.
  task automatic score(input logic [39:0] g, input logic [39:0] t, output int lat, output int nbusy);
    bus.guess  = g;
    bus.target = t;
    bus.Start  = 1'b1;
    lat   = -1;
    nbusy = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge Clk);
      bus.Start = 1'b0;
      if (bus.busy) nbusy++;
      if (bus.done) begin
        lat = n;
        break;
      end
    end
  endtask

  int lat, nb, ndone, first_done;
  logic [9:0] cap_colors;

  initial begin
    reset      = 1'b0;
    bus.Start  = 1'b0;
    bus.guess  = '0;
    bus.target = '0;

    // 1: reset held with Start toggling
    for (int n = 0; n < 4; n++) begin
      @(negedge Clk);
      bus.Start = ~bus.Start;
      bus.guess = "CRANE";
      bus.target = "CRANE";
      check("rst_busy", 40'(bus.busy), 40'(0));
      check("rst_done", 40'(bus.done), 40'(0));
      check("rst_colors", 40'(bus.colors), 40'(0));
      check("rst_win", 40'(bus.win), 40'(0));
    end
    @(negedge Clk);
    bus.Start = 1'b0;
    reset = 1'b1;
    @(negedge Clk);
    check("idle_busy", 40'(bus.busy), 40'(0));

    // 2: exact match
    score("CRANE", "CRANE", lat, nb);
    check("crane_lat", 40'(lat), 40'(31));
    check("crane_busy_cycles", 40'(nb), 40'(31));
    check("crane_colors", 40'(bus.colors), 40'h3FF);
    check("crane_win", 40'(bus.win), 40'(1));
    @(negedge Clk);
    check("crane_done_pulse", 40'(bus.done), 40'(0));
    check("crane_busy_after", 40'(bus.busy), 40'(0));
    check("crane_hold", 40'(bus.colors), 40'h3FF);

    // 3: duplicate guess letter consumed once
    score("SPEED", "ABIDE", lat, nb);
    check("speed_lat", 40'(lat), 40'(31));
    check("speed_colors", 40'(bus.colors), 40'h166);
    check("speed_win", 40'(bus.win), 40'(0));
    @(negedge Clk);

    // 4: green beats yellow
    score("EERIE", "THREE", lat, nb);
    check("eerie_colors", 40'(bus.colors), 40'h277);
    check("eerie_win", 40'(bus.win), 40'(0));
    @(negedge Clk);

    // all grey, including non-alpha bytes compared by equality
    score("XX  X", "ABCDE", lat, nb);
    check("grey_colors", 40'(bus.colors), 40'h155);
    @(negedge Clk);

    // 5: Start pulsed mid-scan is ignored and not queued
    bus.guess  = "ABCDE";
    bus.target = "EDCBA";
    bus.Start  = 1'b1;
    ndone = 0;
    first_done = -1;
    cap_colors = '0;
    for (int n = 1; n <= 70; n++) begin
      @(negedge Clk);
      bus.Start = 1'b0;
      if (n == 10) begin
        bus.Start  = 1'b1;
        bus.guess  = "CRANE";
        bus.target = "CRANE";
      end
      if (n == 5) check("hold_mid_scan", 40'(bus.colors), 40'h155);
      if (bus.done) begin
        ndone++;
        if (first_done < 0) begin
          first_done = n;
          cap_colors = bus.colors;
        end
      end
    end
    check("ignore_ndone", 40'(ndone), 40'(1));
    check("ignore_lat", 40'(first_done), 40'(31));
    check("ignore_colors", 40'(cap_colors), 40'h2BA);
    check("ignore_hold", 40'(bus.colors), 40'h2BA);

    // 6: reset mid-scan aborts
    bus.guess  = "SPEED";
    bus.target = "ABIDE";
    bus.Start  = 1'b1;
    ndone = 0;
    for (int n = 1; n <= 50; n++) begin
      @(negedge Clk);
      bus.Start = 1'b0;
      if (n == 15) reset = 1'b0;
      if (n == 16) begin
        reset = 1'b1;
        check("abort_busy", 40'(bus.busy), 40'(0));
        check("abort_colors", 40'(bus.colors), 40'(0));
        check("abort_win", 40'(bus.win), 40'(0));
      end
      if (bus.done) ndone++;
    end
    check("abort_ndone", 40'(ndone), 40'(0));
    score("CRANE", "CRANE", lat, nb);
    check("post_rst_lat", 40'(lat), 40'(31));
    check("post_rst_colors", 40'(bus.colors), 40'h3FF);
    check("post_rst_win", 40'(bus.win), 40'(1));

    @(negedge Clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
